alu_logic_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit for the Y86-64 execute stage.
- Generalises the fixed 32-bit AND to WIDTH bits and four opcodes (AND/OR/XOR/ANDN).
- Adds Y86 condition flags and a LATENCY-deep valid/ready pipeline with full backpressure.
- Sits between decode/issue and the E-to-M pipeline register.

---
 rtl/alu_logic_pipe.sv | 131 +++++++++++++
 tb/tb_alu_logic_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_logic_pipe.sv
// Pipelined Y86-64 bitwise logic unit (AND/OR/XOR/ANDN) with ZF/SF/OF flags and valid/ready backpressure.
// Optional Y86 condition-code register enabled by defining ALU_LOGIC_CC_EN.
module alu_logic_pipe #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
`ifdef ALU_LOGIC_CC_EN
  input  logic             set_cc,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of
);

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_ANDN = 2'b11
  } op_e;

  op_e              w_op;
  logic [WIDTH-1:0] w_res;
  logic [LATENCY-1:0] w_adv;

  logic [LATENCY-1:0] r_vld;
  logic [WIDTH-1:0]   r_res [LATENCY];
  logic [LATENCY-1:0] r_zf;
  logic [LATENCY-1:0] r_sf;
`ifdef ALU_LOGIC_CC_EN
  logic [LATENCY-1:0] r_set_cc;
`endif

  assign w_op = op_e'(in_op);

  always_comb begin
    w_res = '0;
    case (w_op)
      OP_AND:  w_res = in_a & in_b;
      OP_OR:   w_res = in_a | in_b;
      OP_XOR:  w_res = in_a ^ in_b;
      OP_ANDN: w_res = in_a & ~in_b;
      default: w_res = '0;
    endcase
  end

  // Stage k may advance if any stage from k to the output has a hole, or the
  // consumer drains; expressed per stage so the ready chain has no loop.
  always_comb begin
    w_adv = '0;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      w_adv[k] = out_ready;
      for (int unsigned j = k; j < LATENCY; j++) begin
        if (!r_vld[j]) w_adv[k] = 1'b1;
      end
    end
  end

  assign in_ready = w_adv[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_zf  <= '0;
      r_sf  <= '0;
`ifdef ALU_LOGIC_CC_EN
      r_set_cc <= '0;
`endif
      for (int unsigned k = 0; k < LATENCY; k++) r_res[k] <= '0;
    end else begin
      for (int unsigned k = 1; k < LATENCY; k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_res[k] <= r_res[k-1];
            r_zf[k]  <= r_zf[k-1];
            r_sf[k]  <= r_sf[k-1];
`ifdef ALU_LOGIC_CC_EN
            r_set_cc[k] <= r_set_cc[k-1];
`endif
          end
        end
      end
      if (w_adv[0]) begin
        r_vld[0] <= in_valid;
        if (in_valid) begin
          r_res[0] <= w_res;
          r_zf[0]  <= ~|w_res;
          r_sf[0]  <= w_res[WIDTH-1];
`ifdef ALU_LOGIC_CC_EN
          r_set_cc[0] <= set_cc;
`endif
        end
      end
    end
  end

  assign out_valid = r_vld[LATENCY-1];
  assign out_res   = r_res[LATENCY-1];
  assign out_zf    = r_zf[LATENCY-1];
  assign out_sf    = r_sf[LATENCY-1];
  assign out_of    = 1'b0;

`ifdef ALU_LOGIC_CC_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (out_valid && out_ready && r_set_cc[LATENCY-1]) begin
      cc_zf <= r_zf[LATENCY-1];
      cc_sf <= r_sf[LATENCY-1];
      cc_of <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_logic_pipe.sv
// Self-checking bench for alu_logic_pipe: two configurations (32b/2-stage, 64b/1-stage),
// directed tables, backpressure/reset sequences and randomized scoreboard checking.
module tb_alu_logic_pipe;
  localparam int W0 = 32;
  localparam int L0 = 2;
  localparam int W1 = 64;
  localparam int L1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic v0, r0, ov0, or0, zf0, sf0, of0;
  logic [W0-1:0] a0, b0, res0;
  logic [1:0] op0;
  logic v1, r1, ov1, or1, zf1, sf1, of1;
  logic [W1-1:0] a1, b1, res1;
  logic [1:0] op1;
`ifdef ALU_LOGIC_CC_EN
  logic sc0, ccz0, ccs0, cco0;
  logic sc1, ccz1, ccs1, cco1;
`endif

  alu_logic_pipe #(.WIDTH(W0), .LATENCY(L0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0),
    .in_a(a0), .in_b(b0), .in_op(op0),
`ifdef ALU_LOGIC_CC_EN
    .set_cc(sc0), .cc_zf(ccz0), .cc_sf(ccs0), .cc_of(cco0),
`endif
    .out_valid(ov0), .out_ready(or0), .out_res(res0),
    .out_zf(zf0), .out_sf(sf0), .out_of(of0)
  );

  alu_logic_pipe #(.WIDTH(W1), .LATENCY(L1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1),
    .in_a(a1), .in_b(b1), .in_op(op1),
`ifdef ALU_LOGIC_CC_EN
    .set_cc(sc1), .cc_zf(ccz1), .cc_sf(ccs1), .cc_of(cco1),
`endif
    .out_valid(ov1), .out_ready(or1), .out_res(res1),
    .out_zf(zf1), .out_sf(sf1), .out_of(of1)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit exact_lat = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [63:0] res;
    logic        zf;
    logic        sf;
    logic        sc;
    int          cyc;
  } exp_t;

  // Reference: result defined directly from the opcode table, masked to the width.
  function automatic exp_t mk(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                              input int w, input logic sc, input int c);
    exp_t e;
    logic [63:0] r;
    logic [63:0] m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case (op)
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = a ^ b;
      default: r = a & ~b;
    endcase
    r = r & m;
    e.res = r;
    e.zf  = (r == 64'd0);
    e.sf  = r[w-1];
    e.sc  = sc;
    e.cyc = c;
    return e;
  endfunction

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic stall0 = 1'b0, stall1 = 1'b0;
  logic [W0-1:0] hres0;
  logic [W1-1:0] hres1;
  logic hzf0, hsf0, hzf1, hsf1;
  logic [2:0] mcc0 = 3'b100, mcc1 = 3'b100;

  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      stall0 = 1'b0;
      mcc0 = 3'b100;
    end else begin
      if (stall0) begin
        chk("hold_valid0", 64'(ov0), 64'd1);
        chk("hold_res0", 64'(res0), 64'(hres0));
        chk("hold_flags0", 64'({zf0, sf0}), 64'({hzf0, hsf0}));
      end
`ifdef ALU_LOGIC_CC_EN
      chk("cc0", 64'({ccz0, ccs0, cco0}), 64'(mcc0));
`endif
      if (ov0 && or0) begin
        if (q0.size() == 0) chk("spurious_out0", 64'(ov0), 64'd0);
        else begin
          e0 = q0.pop_front();
          chk("res0", 64'(res0), e0.res);
          chk("flags0", 64'({zf0, sf0, of0}), 64'({e0.zf, e0.sf, 1'b0}));
          if (exact_lat) chk("lat0", 64'(cyc - e0.cyc), 64'(L0));
          else chk("lat0_min", 64'(cyc - e0.cyc >= L0), 64'd1);
          if (e0.sc) mcc0 = {e0.zf, e0.sf, 1'b0};
        end
      end
`ifdef ALU_LOGIC_CC_EN
      if (v0 && r0) q0.push_back(mk(64'(a0), 64'(b0), op0, W0, sc0, cyc));
`else
      if (v0 && r0) q0.push_back(mk(64'(a0), 64'(b0), op0, W0, 1'b0, cyc));
`endif
      stall0 = ov0 && !or0;
      hres0 = res0; hzf0 = zf0; hsf0 = sf0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete();
      stall1 = 1'b0;
      mcc1 = 3'b100;
    end else begin
      if (stall1) begin
        chk("hold_valid1", 64'(ov1), 64'd1);
        chk("hold_res1", res1, 64'(hres1));
        chk("hold_flags1", 64'({zf1, sf1}), 64'({hzf1, hsf1}));
      end
`ifdef ALU_LOGIC_CC_EN
      chk("cc1", 64'({ccz1, ccs1, cco1}), 64'(mcc1));
`endif
      if (ov1 && or1) begin
        if (q1.size() == 0) chk("spurious_out1", 64'(ov1), 64'd0);
        else begin
          e1 = q1.pop_front();
          chk("res1", res1, e1.res);
          chk("flags1", 64'({zf1, sf1, of1}), 64'({e1.zf, e1.sf, 1'b0}));
          if (exact_lat) chk("lat1", 64'(cyc - e1.cyc), 64'(L1));
          else chk("lat1_min", 64'(cyc - e1.cyc >= L1), 64'd1);
          if (e1.sc) mcc1 = {e1.zf, e1.sf, 1'b0};
        end
      end
`ifdef ALU_LOGIC_CC_EN
      if (v1 && r1) q1.push_back(mk(a1, b1, op1, W1, sc1, cyc));
`else
      if (v1 && r1) q1.push_back(mk(a1, b1, op1, W1, 1'b0, cyc));
`endif
      stall1 = ov1 && !or1;
      hres1 = res1; hzf1 = zf1; hsf1 = sf1;
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    logic        zf;
    logic        sf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{32'h0000000B, 32'h00000004, 2'b00, 32'h00000000, 1'b1, 1'b0};
    tbl[1] = '{32'hFFFFFFF5, 32'h0000000C, 2'b00, 32'h00000004, 1'b0, 1'b0};
    tbl[2] = '{32'hFFFFFFFE, 32'hFFFFFFF3, 2'b00, 32'hFFFFFFF2, 1'b0, 1'b1};
    tbl[3] = '{32'h00000009, 32'h00000006, 2'b01, 32'h0000000F, 1'b0, 1'b0};
    tbl[4] = '{32'h00000009, 32'h00000009, 2'b10, 32'h00000000, 1'b1, 1'b0};
    tbl[5] = '{32'h000000FF, 32'h0000000F, 2'b11, 32'h000000F0, 1'b0, 1'b0};

    rst_n = 1'b0;
    v0 = 1'b0; a0 = '0; b0 = '0; op0 = '0; or0 = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; op1 = '0; or1 = 1'b1;
`ifdef ALU_LOGIC_CC_EN
    sc0 = 1'b0; sc1 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out", 64'({ov0, zf0, sf0, of0}), 64'd0);
    chk("rst_res", 64'(res0), 64'd0);
    chk("rst_ready", 64'({r0, r1}), 64'b11);
    chk("rst_out1", 64'({ov1, zf1, sf1, of1}), 64'd0);
    chk("rst_res1", res1, 64'd0);
`ifdef ALU_LOGIC_CC_EN
    chk("rst_cc", 64'({ccz0, ccs0, cco0}), 64'b100);
`endif

    // Back-to-back table with exact position-based latency check
    for (int i = 0; i < 6 + L0; i++) begin
      @(posedge clk); #1;
      if (i < 6) begin
        v0 = 1'b1; a0 = tbl[i].a; b0 = tbl[i].b; op0 = tbl[i].op;
      end else v0 = 1'b0;
      @(negedge clk);
      chk("tbl_ready", 64'(r0), 64'd1);
      if (i >= L0) begin
        chk("tbl_valid", 64'(ov0), 64'd1);
        chk("tbl_res", 64'(res0), 64'(tbl[i-L0].res));
        chk("tbl_flags", 64'({zf0, sf0, of0}), 64'({tbl[i-L0].zf, tbl[i-L0].sf, 1'b0}));
      end
    end

    // 64-bit, single stage: sign bit result one cycle after acceptance
    @(posedge clk); #1;
    v1 = 1'b1; a1 = 64'h8000000000000000; b1 = '0; op1 = 2'b10;
    @(negedge clk); chk("w64_ready", 64'(r1), 64'd1);
    @(posedge clk); #1 v1 = 1'b0;
    @(negedge clk);
    chk("w64_valid", 64'(ov1), 64'd1);
    chk("w64_res", res1, 64'h8000000000000000);
    chk("w64_flags", 64'({zf1, sf1, of1}), 64'b010);

    // Backpressure: two fill the pipe, the third waits until release
    @(posedge clk); #1;
    or0 = 1'b0; v0 = 1'b1; a0 = 32'h1; b0 = 32'h3; op0 = 2'b01;
    @(negedge clk); chk("bp_ready_a", 64'(r0), 64'd1);
    @(posedge clk); #1 a0 = 32'h5; b0 = 32'h3; op0 = 2'b10;
    @(negedge clk); chk("bp_ready_b", 64'(r0), 64'd1);
    @(posedge clk); #1 a0 = 32'hF0F0; b0 = 32'hFF00; op0 = 2'b00;
    @(negedge clk);
    chk("bp_full_ready", 64'(r0), 64'd0);
    chk("bp_head", 64'({ov0, res0}), {31'd0, 1'b1, 32'h3});
    repeat (2) begin
      @(negedge clk);
      chk("bp_stall_ready", 64'(r0), 64'd0);
      chk("bp_stall_res", 64'(res0), 64'h3);
    end
    @(posedge clk); #1 or0 = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(r0), 64'd1);
    chk("bp_release_res", 64'(res0), 64'h3);
    @(posedge clk); #1 v0 = 1'b0;
    @(negedge clk); chk("bp_drain_b", 64'({ov0, res0}), {31'd0, 1'b1, 32'h6});
    @(negedge clk); chk("bp_drain_c", 64'({ov0, res0}), {31'd0, 1'b1, 32'hF000});
    @(negedge clk); chk("bp_empty", 64'(ov0), 64'd0);

`ifdef ALU_LOGIC_CC_EN
    // CC: set to zf=0, then zf=1 by AND 3&C, then untouched by set_cc=0
    @(posedge clk); #1 v0 = 1'b1; sc0 = 1'b1; a0 = 32'h1; b0 = 32'h0; op0 = 2'b01;
    @(posedge clk); #1 v0 = 1'b0; sc0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); chk("cc_set0", 64'({ccz0, ccs0, cco0}), 64'b000);
    @(posedge clk); #1 v0 = 1'b1; sc0 = 1'b1; a0 = 32'h3; b0 = 32'hC; op0 = 2'b00;
    @(posedge clk); #1 v0 = 1'b0; sc0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); chk("cc_and_zf", 64'({ccz0, ccs0, cco0}), 64'b100);
    @(posedge clk); #1 v0 = 1'b1; sc0 = 1'b0; a0 = 32'h1; b0 = 32'h0; op0 = 2'b01;
    @(posedge clk); #1 v0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); chk("cc_hold", 64'({ccz0, ccs0, cco0}), 64'b100);
`endif

    // Reset with two bundles in flight
    @(posedge clk); #1 v0 = 1'b1; a0 = 32'h12; b0 = 32'h34; op0 = 2'b01;
    @(posedge clk); #1 a0 = 32'h56; b0 = 32'h78; op0 = 2'b10;
    @(posedge clk); #1 v0 = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(ov0), 64'd0);
    chk("mid_rst_ready", 64'(r0), 64'd1);
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_no_stale", 64'(ov0), 64'd0);
    end

    // Random, consumer always ready: latency must be exact
    exact_lat = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      v0 = 1'($urandom_range(0, 1)); a0 = $urandom; b0 = $urandom; op0 = 2'($urandom);
      v1 = 1'($urandom_range(0, 1)); a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      op1 = 2'($urandom);
`ifdef ALU_LOGIC_CC_EN
      sc0 = 1'($urandom); sc1 = 1'($urandom);
`endif
    end
    @(posedge clk); #1 v0 = 1'b0; v1 = 1'b0;
    repeat (6) @(posedge clk);
    #1 exact_lat = 1'b0;

    // Random with backpressure
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      or0 = ($urandom_range(0, 3) != 0); or1 = ($urandom_range(0, 3) != 0);
      v0 = 1'($urandom_range(0, 1)); a0 = $urandom; b0 = $urandom; op0 = 2'($urandom);
      v1 = 1'($urandom_range(0, 1)); a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      op1 = 2'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        b0 = a0; op0 = 2'b10;
      end
`ifdef ALU_LOGIC_CC_EN
      sc0 = 1'($urandom); sc1 = 1'($urandom);
`endif
    end
    @(posedge clk); #1 v0 = 1'b0; v1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("drain0", 64'(q0.size()), 64'd0);
    chk("drain1", 64'(q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
